// File: rtl/connection_block_cfg_pkg.sv
// Shared definitions for the connection_block configuration loader:
// loader state encoding and the switch-control width calculation.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL
  } cfg_state_t;

  localparam int CB_CFG_W_DEFAULT = 212;

  // Width of connection_block's c vector; loader and block instances must agree on it.
  function automatic int cb_cfg_width(
    input int clbout0,
    input int clbos,
    input int clbod,
    input int clbin0,
    input int ws,
    input int wd,
    input int wg,
    input int clbx,
    input int clbout1,
    input int clbin1
  );
    return clbout0 * (clbos + clbod)
         + clbin0  * (ws + wd + wg + clbx * clbout1)
         + clbout1 * (clbos + clbod)
         + clbin1  * (ws + wd + wg + clbx * clbout0);
  endfunction

endpackage

// File: rtl/connection_block_cfg_if.sv
// Serial configuration port of one loader tile: daisy-chain bit stream,
// global commit/clear pulses and the resulting switch-control vector.
interface connection_block_cfg_if #(
  parameter int CFG_W = 212,
  parameter int CNT_W = $clog2(CFG_W + 1)
);

  logic             cfg_valid;
  logic             cfg_in;
  logic             cfg_commit;
  logic             cfg_clear;
  logic             cfg_out;
  logic             cfg_out_valid;
  logic [CFG_W-1:0] c;
  logic             cfg_active;
  logic             cfg_err;
  logic [CNT_W-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_in, cfg_commit, cfg_clear,
    input  cfg_out, cfg_out_valid, c, cfg_active, cfg_err, cfg_count
  );

  modport slave (
    input  cfg_valid, cfg_in, cfg_commit, cfg_clear,
    output cfg_out, cfg_out_valid, c, cfg_active, cfg_err, cfg_count
  );

endinterface

// File: rtl/connection_block_cfg_shift_counter.sv
// Shadow shift register plus saturating load counter for one loader tile.
// Requires CFG_W >= 2.
module cfg_shift_counter #(
  parameter int CFG_W = 212,
  parameter int CNT_W = $clog2(CFG_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             restart,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CFG_W-1:0] sr,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(CFG_W));

  // Commit only restarts the count; sr is kept so the committed image stays readable.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sr    <= '0;
      count <= '0;
    end else begin
      if (shift_en) begin
        sr <= {bit_in, sr[CFG_W-1:1]};
      end
      if (restart) begin
        count <= '0;
      end else if (shift_en && !full) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/connection_block_cfg.sv
// Configuration loader for connection_block: shifts the bitstream into a
// shadow register and transfers it to c only on a global commit.
module connection_block_cfg
  import cb_cfg_pkg::*;
#(
  parameter int CFG_W = CB_CFG_W_DEFAULT,
  parameter int CNT_W = $clog2(CFG_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  connection_block_cfg_if.slave bus
);

  logic             flush;
  logic             shift_en;
  logic             last_bit;
  logic [CFG_W-1:0] sr;
  logic [CNT_W-1:0] count;
  logic             full;
  cfg_state_t       state_q;
  cfg_state_t       state_d;

  logic [CFG_W-1:0] c_q;
  logic             active_q;
  logic             err_q;
  logic             out_q;
  logic             out_valid_q;

  // A shift coinciding with a global pulse is dropped chain-wide.
  assign flush    = bus.cfg_clear | bus.cfg_commit;
  assign shift_en = bus.cfg_valid & ~flush;
  assign last_bit = (count == CNT_W'(CFG_W - 1));

  cfg_shift_counter #(
    .CFG_W (CFG_W),
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.cfg_clear),
    .restart  (bus.cfg_commit),
    .shift_en (shift_en),
    .bit_in   (bus.cfg_in),
    .sr       (sr),
    .count    (count),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (shift_en) begin
      case (state_q)
        EMPTY, LOADING: state_d = (last_bit || full) ? FULL : LOADING;
        FULL:           state_d = FULL;
        default:        state_d = EMPTY;
      endcase
    end
  end

  // c only moves on reset, clear or commit, so routing never sees partial data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q         <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= shift_en;
      if (shift_en) begin
        out_q <= sr[0];
      end
      if (bus.cfg_clear) begin
        c_q      <= '0;
        active_q <= 1'b0;
        err_q    <= 1'b0;
      end else if (bus.cfg_commit) begin
        if (state_q == FULL) begin
          c_q      <= sr;
          active_q <= 1'b1;
        end else begin
          c_q      <= '0;
          active_q <= 1'b0;
          err_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.c             = c_q;
  assign bus.cfg_active    = active_q;
  assign bus.cfg_err       = err_q;
  assign bus.cfg_out       = out_q;
  assign bus.cfg_out_valid = out_valid_q;
  assign bus.cfg_count     = count;

endmodule

// File: tb/tb_connection_block_cfg.sv
// Scoreboard bench: two chained 8-bit loaders plus one default-width loader,
// checked against a queue-based model of the shadow register.
module tb_connection_block_cfg;

  localparam int WS = 8;
  localparam int WL = 212;

  typedef struct packed {
    logic [WL-1:0] c;
    logic          act;
    logic          err;
    logic          ob;
  } stat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  connection_block_cfg_if #(.CFG_W(WS)) up_if ();
  connection_block_cfg_if #(.CFG_W(WS)) dn_if ();
  connection_block_cfg_if #(.CFG_W(WL)) wd_if ();

  connection_block_cfg #(.CFG_W(WS)) u_up (.clk(clk), .rst_n(rst_n), .bus(up_if.slave));
  connection_block_cfg #(.CFG_W(WS)) u_dn (.clk(clk), .rst_n(rst_n), .bus(dn_if.slave));
  connection_block_cfg #(.CFG_W(WL)) u_wd (.clk(clk), .rst_n(rst_n), .bus(wd_if.slave));

  assign dn_if.cfg_in     = up_if.cfg_out;
  assign dn_if.cfg_valid  = up_if.cfg_out_valid;
  assign dn_if.cfg_commit = up_if.cfg_commit;
  assign dn_if.cfg_clear  = up_if.cfg_clear;
  assign wd_if.cfg_commit = up_if.cfg_commit;
  assign wd_if.cfg_clear  = up_if.cfg_clear;

  int            wid [3] = '{WS, WS, WL};
  bit            srq [3][$];
  int            cnt [3];
  bit            act [3];
  bit            err [3];
  bit            lastob [3];
  logic [WL-1:0] cexp [3];
  stat_t         statq [3][$];
  bit            outq [3][$];
  int            cntq [3][$];
  bit            pend_v = 1'b0;
  bit            pend_b = 1'b0;
  int            compared = 0;
  int            mismatched = 0;

  task automatic cmp(input string name, input int i, input logic [WL-1:0] got, input logic [WL-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h", name, i, got, exp);
    end
  endtask

  task automatic resetModel(input int i);
    srq[i].delete();
    for (int k = 0; k < wid[i]; k++) srq[i].push_back(1'b0);
    cnt[i]  = 0;
    cexp[i] = '0;
    act[i]  = 1'b0;
    err[i]  = 1'b0;
  endtask

  // Model: srq[i][0] is the oldest retained bit; a full image maps srq[k] to c[k].
  task automatic stepModel(input int i, input bit rst, input bit clr, input bit cmt,
                           input bit vld, input bit bin, output bit acc, output bit ob);
    stat_t s;
    acc = 1'b0;
    ob  = 1'b0;
    if (rst) begin
      resetModel(i);
      lastob[i] = 1'b0;
    end else if (clr) begin
      resetModel(i);
    end else if (cmt) begin
      if (cnt[i] == wid[i]) begin
        cexp[i] = '0;
        for (int k = 0; k < wid[i]; k++) cexp[i][k] = srq[i][k];
        act[i] = 1'b1;
      end else begin
        cexp[i] = '0;
        act[i]  = 1'b0;
        err[i]  = 1'b1;
      end
      cnt[i] = 0;
    end else if (vld) begin
      ob = srq[i].pop_front();
      srq[i].push_back(bin);
      if (cnt[i] < wid[i]) cnt[i]++;
      lastob[i] = ob;
      acc = 1'b1;
      outq[i].push_back(ob);
    end
    if (rst || clr || cmt) begin
      s.c   = cexp[i];
      s.act = act[i];
      s.err = err[i];
      s.ob  = lastob[i];
      statq[i].push_back(s);
    end
    cntq[i].push_back(cnt[i]);
  endtask

  task automatic applyStimulus(input bit rst, input bit clr, input bit cmt,
                               input bit vld, input bit bin, input bit vld2, input bit bin2);
    bit acc, ob, dacc, dob, wacc, wob;
    rst_n             = ~rst;
    up_if.cfg_clear   = clr;
    up_if.cfg_commit  = cmt;
    up_if.cfg_valid   = vld;
    up_if.cfg_in      = bin;
    wd_if.cfg_valid   = vld2;
    wd_if.cfg_in      = bin2;
    stepModel(1, rst, clr, cmt, pend_v, pend_b, dacc, dob);
    stepModel(0, rst, clr, cmt, vld, bin, acc, ob);
    pend_v = acc;
    pend_b = ob;
    stepModel(2, rst, clr, cmt, vld2, bin2, wacc, wob);
    @(negedge clk);
  endtask

  task automatic checkOutput(input int i, input logic [WL-1:0] c, input logic a, input logic e,
                             input logic ov, input logic ob, input logic [WL-1:0] count, input bit ev);
    stat_t s;
    bit    b;
    bit    want_ov;
    if (cntq[i].size() == 0) begin
      cmp("count_queue_empty", i, WL'(1), WL'(0));
    end else begin
      cmp("cfg_count", i, count, WL'(cntq[i].pop_front()));
    end
    want_ov = (outq[i].size() != 0);
    cmp("cfg_out_valid", i, WL'(ov), WL'(want_ov));
    if (want_ov) begin
      b = outq[i].pop_front();
      cmp("cfg_out", i, WL'(ob), WL'(b));
    end
    if (ev) begin
      if (statq[i].size() == 0) begin
        cmp("status_queue_empty", i, WL'(1), WL'(0));
      end else begin
        s = statq[i].pop_front();
        cmp("c", i, c, s.c);
        cmp("cfg_active", i, WL'(a), WL'(s.act));
        cmp("cfg_err", i, WL'(e), WL'(s.err));
        cmp("cfg_out_hold", i, WL'(ob), WL'(s.ob));
      end
    end
  endtask

  // Monitor: samples the global pulses at the edge, checks outputs just after it.
  initial begin
    bit ev;
    forever begin
      @(posedge clk);
      ev = (rst_n !== 1'b1) || (up_if.cfg_clear === 1'b1) || (up_if.cfg_commit === 1'b1);
      #1;
      checkOutput(0, WL'(up_if.c), up_if.cfg_active, up_if.cfg_err, up_if.cfg_out_valid,
                  up_if.cfg_out, WL'(up_if.cfg_count), ev);
      checkOutput(1, WL'(dn_if.c), dn_if.cfg_active, dn_if.cfg_err, dn_if.cfg_out_valid,
                  dn_if.cfg_out, WL'(dn_if.cfg_count), ev);
      checkOutput(2, wd_if.c, wd_if.cfg_active, wd_if.cfg_err, wd_if.cfg_out_valid,
                  wd_if.cfg_out, WL'(wd_if.cfg_count), ev);
    end
  end

  initial begin
    bit            pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [WL-1:0] vec;
    bit            b;
    bit            rst, clr, cmt;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 1'($urandom), 1, 1'($urandom));
    applyStimulus(1, 0, 0, 1, 1, 1, 1);
    cmp("reset_mid_load_count", 0, WL'(up_if.cfg_count), WL'(0));
    cmp("reset_mid_load_c", 2, wd_if.c, WL'(0));

    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, pat[k], 1, 1'($urandom));
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cmp("full_load_c", 0, WL'(up_if.c), WL'(8'h4D));
    cmp("full_load_active", 0, WL'(up_if.cfg_active), WL'(1));
    cmp("full_load_err", 0, WL'(up_if.cfg_err), WL'(0));

    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cmp("early_commit_err", 0, WL'(up_if.cfg_err), WL'(1));
    cmp("early_commit_c", 0, WL'(up_if.c), WL'(0));
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    cmp("clear_err", 0, WL'(up_if.cfg_err), WL'(0));

    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, 1, (k == 0), 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cmp("chain_down_c", 1, WL'(dn_if.c), WL'(8'h01));
    cmp("chain_up_c", 0, WL'(up_if.c), WL'(0));

    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, 1'($urandom), 1, 1'($urandom));
    applyStimulus(0, 0, 1, 1, 1, 1, 1);
    cmp("commit_drops_shift", 0, WL'(up_if.cfg_out_valid), WL'(0));
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 0);
    cmp("clear_beats_commit_err", 0, WL'(up_if.cfg_err), WL'(0));

    vec = '0;
    for (int k = 0; k < WL; k++) begin
      b = 1'($urandom);
      vec[k] = b;
      applyStimulus(0, 0, 0, 0, 0, 1, b);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cmp("wide_c", 2, wd_if.c, vec);
    cmp("wide_active", 2, WL'(wd_if.cfg_active), WL'(1));

    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 39) == 0);
      cmt = ($urandom_range(0, 24) == 0);
      applyStimulus(rst, clr, cmt, ($urandom_range(0, 3) != 0), 1'($urandom),
                    ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cmp("leftover_out", i, WL'(outq[i].size()), WL'(0));
      cmp("leftover_status", i, WL'(statq[i].size()), WL'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
